// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: per-channel rising-edge counts over fixed windows,
// handed off over valid/ready, plus one PWM motor output per channel.
module spike_rate_decoder #(
    parameter int NCH    = 2,
    parameter int CNT_W  = 10,
    parameter int WINDOW = 2500,
    parameter int PWM_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NCH-1:0]       spike_in,
    output logic [NCH*CNT_W-1:0] count_out,
    output logic                 count_valid,
    input  logic                 count_ready,
    output logic                 overrun,
    output logic [NCH-1:0]       pwm_out
);

    localparam int               TMR_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a,
                                                  input logic             inc);
        if (inc && (a != {CNT_W{1'b1}})) begin
            return a + CNT_W'(1);
        end
        return a;
    endfunction

    function automatic logic [PWM_W-1:0] duty_clip(input logic [CNT_W-1:0] c);
        if ((c >> PWM_W) != '0) begin
            return {PWM_W{1'b1}};
        end
        return PWM_W'(c);
    endfunction

    logic [NCH-1:0]   spike_prev_p0;
    logic [NCH-1:0]   edge_det;
    logic [TMR_W-1:0] timer_p1;
    logic [PWM_W-1:0] pwm_cnt_p1;
    logic [CNT_W-1:0] acc_p1  [NCH];
    logic [CNT_W-1:0] closing [NCH];
    logic [CNT_W-1:0] hold_p2 [NCH];
    logic [PWM_W-1:0] duty_p2 [NCH];
    logic             vld_p2;
    logic             overrun_p2;
    logic [NCH-1:0]   pwm_p2;
    logic             tick;
    logic             xfer;

    // Stage p0: edge detection against the last enabled-cycle sample
    assign edge_det = spike_in & ~spike_prev_p0 & {NCH{en}};
    assign tick     = en && (timer_p1 == TMR_LAST);
    assign xfer     = vld_p2 && count_ready;

    // An edge landing in the tick cycle is folded into the closing window
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            closing[i] = sat_inc(acc_p1[i], edge_det[i]);
        end
    end

    // Stage p1: window timer, accumulators, PWM counter (all frozen while en is low)
    always_ff @(posedge clk) begin
        if (!rst) begin
            spike_prev_p0 <= '0;
            timer_p1      <= '0;
            pwm_cnt_p1    <= '0;
            for (int i = 0; i < NCH; i++) begin
                acc_p1[i] <= '0;
            end
        end else if (en) begin
            spike_prev_p0 <= spike_in;
            timer_p1      <= tick ? '0 : timer_p1 + TMR_W'(1);
            pwm_cnt_p1    <= pwm_cnt_p1 + PWM_W'(1);
            for (int i = 0; i < NCH; i++) begin
                acc_p1[i] <= tick ? '0 : closing[i];
            end
        end
    end

    // Stage p2: holding registers, duty, handshake and PWM compare
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p2     <= 1'b0;
            overrun_p2 <= 1'b0;
            pwm_p2     <= '0;
            for (int i = 0; i < NCH; i++) begin
                hold_p2[i] <= '0;
                duty_p2[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                pwm_p2[i] <= en && (pwm_cnt_p1 < duty_p2[i]);
            end
            if (tick) begin
                for (int i = 0; i < NCH; i++) begin
                    hold_p2[i] <= closing[i];
                    duty_p2[i] <= duty_clip(closing[i]);
                end
                vld_p2 <= 1'b1;
                if (vld_p2 && !count_ready) begin
                    overrun_p2 <= 1'b1;
                end
            end else if (xfer) begin
                vld_p2 <= 1'b0;
            end
        end
    end

    always_comb begin
        count_out = '0;
        for (int i = 0; i < NCH; i++) begin
            count_out[i*CNT_W +: CNT_W] = hold_p2[i];
        end
    end

    assign count_valid = vld_p2;
    assign overrun     = overrun_p2;
    assign pwm_out     = pwm_p2;

endmodule
